// File: rtl/ledr_share_if.sv
// Requester handshakes and PIO slave bus shared by the LED arbiter and its users.
interface ledr_share_if;
  logic        req0;
  logic [7:0]  wdata0;
  logic        ack0;
  logic        req1;
  logic [7:0]  wdata1;
  logic        ack1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        busy;
  logic        last_owner;

  modport slave (
    input  req0, wdata0, req1, wdata1,
    output ack0, ack1, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, busy, last_owner
  );

  modport master (
    output req0, wdata0, req1, wdata1,
    input  ack0, ack1, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, busy, last_owner
  );
endinterface

// File: rtl/ledr_share_arbiter.sv
// Round-robin arbiter sharing one LED PIO register between two requesters;
// each write is followed by a fixed idle hold before the next grant.
module ledr_share_arbiter #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  ledr_share_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t      state;
  logic [15:0] hold_cnt;
  logic [7:0]  latched;
  logic        owner;
  logic        ack0;
  logic        ack1;
  logic        chipselect;
  logic        write_n;
  logic        busy;
  logic        any_req;
  logic        winner;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  assign any_req = bus.req0 | bus.req1;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) winner = ~owner;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= 16'd0;
      latched    <= 8'd0;
      owner      <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= WRITE;
            owner      <= winner;
            latched    <= winner ? bus.wdata1 : bus.wdata0;
            ack0       <= ~winner;
            ack1       <= winner;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        WRITE: begin
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
        end
        HOLD: begin
          if (hold_cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0           = ack0;
  assign bus.ack1           = ack1;
  assign bus.pio_address    = 2'b00;
  assign bus.pio_chipselect = chipselect;
  assign bus.pio_write_n    = write_n;
  assign bus.pio_writedata  = {24'h000000, latched};
  assign bus.busy           = busy;
  assign bus.last_owner     = owner;

endmodule

// File: tb/tb_ledr_share_arbiter.sv
// Directed bench for ledr_share_arbiter with a write scoreboard (HOLD_CYCLES=4).
module tb_ledr_share_arbiter;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  ledr_share_if bus ();

  ledr_share_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b0) break;
      step();
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"},    {31'd0, bus.pio_chipselect}, 32'd0);
    chk({tag, "_wn"},    {31'd0, bus.pio_write_n},    32'd1);
    chk({tag, "_addr"},  {30'd0, bus.pio_address},    32'd0);
    chk({tag, "_wdata"}, bus.pio_writedata,           32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},           32'd0);
    chk({tag, "_owner"}, {31'd0, bus.last_owner},     32'd1);
    chk({tag, "_acks"},  {30'd0, bus.ack1, bus.ack0}, 32'd0);
  endtask

  // Scoreboard: every PIO write cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.pio_chipselect === 1'b1) begin
      chk("sb_pending", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_wdata", bus.pio_writedata, {24'd0, e.data});
        chk("sb_write_n", {31'd0, bus.pio_write_n}, 32'd0);
        chk("sb_acks", {30'd0, bus.ack1, bus.ack0}, e.owner ? 32'd2 : 32'd1);
        chk("sb_owner", {31'd0, bus.last_owner}, {31'd0, e.owner});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.wdata0 = 8'h00;
    bus.wdata1 = 8'h00;
    step();
    step();
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Single requester write, latency and busy window.
    bus.req0 = 1'b1; bus.wdata0 = 8'hA5;
    sb.push_back('{owner: 1'b0, data: 8'hA5});
    step();
    chk("a5_cs",    {31'd0, bus.pio_chipselect}, 32'd1);
    chk("a5_wdata", bus.pio_writedata, 32'h000000A5);
    chk("a5_ack0",  {31'd0, bus.ack0}, 32'd1);
    chk("a5_busy",  {31'd0, bus.busy}, 32'd1);
    bus.req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("a5_hold_busy", {31'd0, bus.busy}, 32'd1);
      chk("a5_hold_cs",   {31'd0, bus.pio_chipselect}, 32'd0);
      chk("a5_hold_data", bus.pio_writedata, 32'h000000A5);
    end
    step();
    chk("a5_idle", {31'd0, bus.busy}, 32'd0);

    // Data captured at grant; later wdata change ignored.
    bus.req0 = 1'b1; bus.wdata0 = 8'h11;
    sb.push_back('{owner: 1'b0, data: 8'h11});
    step();
    bus.wdata0 = 8'h22; bus.req0 = 1'b0;
    step();
    chk("latch_hold_data", bus.pio_writedata, 32'h00000011);
    wait_idle();

    // req1 pulsed only during WRITE is lost.
    bus.req0 = 1'b1; bus.wdata0 = 8'h33;
    sb.push_back('{owner: 1'b0, data: 8'h33});
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.wdata1 = 8'h44;
    step();
    bus.req1 = 1'b0;
    wait_idle();
    step();
    step();
    chk("pulse_no_busy", {31'd0, bus.busy}, 32'd0);
    chk("pulse_no_ack1", {31'd0, bus.ack1}, 32'd0);

    // req1 raised during HOLD waits for IDLE.
    bus.req0 = 1'b1; bus.wdata0 = 8'h55;
    sb.push_back('{owner: 1'b0, data: 8'h55});
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.wdata1 = 8'h66;
    sb.push_back('{owner: 1'b1, data: 8'h66});
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_grant", {30'd0, bus.ack1, bus.pio_chipselect}, 32'd0);
    end
    step();
    chk("hold_back_idle", {31'd0, bus.busy}, 32'd0);
    step();
    chk("late_req1_ack1",  {31'd0, bus.ack1}, 32'd1);
    chk("late_req1_wdata", bus.pio_writedata, 32'h00000066);
    bus.req1 = 1'b0;
    wait_idle();

    // Both held after reset: 01, 02, 01 spaced six cycles.
    reset_n = 1'b0;
    step();
    chk("rr_reset_owner", {31'd0, bus.last_owner}, 32'd1);
    bus.req0 = 1'b1; bus.wdata0 = 8'h01;
    bus.req1 = 1'b1; bus.wdata1 = 8'h02;
    sb.push_back('{owner: 1'b0, data: 8'h01});
    sb.push_back('{owner: 1'b1, data: 8'h02});
    sb.push_back('{owner: 1'b0, data: 8'h01});
    reset_n = 1'b1;
    step();
    chk("rr_w1", bus.pio_writedata, 32'h00000001);
    chk("rr_ack0", {30'd0, bus.ack1, bus.ack0}, 32'd1);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) step();
      chk("rr_gap_cs", {31'd0, bus.pio_chipselect}, 32'd0);
      step();
      chk("rr_space_cs", {31'd0, bus.pio_chipselect}, 32'd1);
      chk("rr_wdata", bus.pio_writedata, (w == 0) ? 32'h00000002 : 32'h00000001);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();

    // Reset during HOLD aborts; held req0 re-issues right after release.
    bus.req0 = 1'b1; bus.wdata0 = 8'h77;
    sb.push_back('{owner: 1'b1, data: 8'h02});
    step();
    chk("pre_abort_ack1", {31'd0, bus.ack1}, 32'd0);
    void'(sb.pop_back());
    sb.push_back('{owner: 1'b0, data: 8'h77});
    step();
    step();
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    step();
    chk("abort_still_idle", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    sb.push_back('{owner: 1'b0, data: 8'h77});
    step();
    chk("rerun_cs",   {31'd0, bus.pio_chipselect}, 32'd1);
    chk("rerun_ack0", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1'b0;
    wait_idle();
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
